// File: rtl/ztex_nonce_fifo.sv
// ztex_nonce_fifo: captures every new golden nonce from the hashing core into
// a small FIFO so the host can read results one at a time without losing any.
//
// Ports:
//   clk          - hashing clock, all logic on posedge
//   reset        - synchronous active-high reset
//   golden_nonce - core golden nonce; a change means a new result was found
//   nonce2       - core live nonce (debug), registered and passed through
//   hash2        - core live hash word (debug), registered and passed through
//   pop          - one-cycle pulse discarding the head entry
//   result       - {hash2_q, nonce2_q, head}; head reads 0 while empty
//   empty        - FIFO holds no entries
//   count        - number of stored entries, 0..DEPTH
//   overflow     - sticky flag, set when a capture is dropped on a full FIFO
//   drop_cnt     - saturating count of dropped captures
module ztex_nonce_fifo #(
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          golden_nonce,
    input  logic [31:0]          nonce2,
    input  logic [31:0]          hash2,
    input  logic                 pop,
    output logic [95:0]          result,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CW    = ADDR_BITS + 1;

    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(DEPTH);

    logic [31:0] golden_q;
    logic [31:0] nonce2_q;
    logic [31:0] hash2_q;
    logic [31:0] last_q;

    logic [31:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;

    logic                 push;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;
    logic                 drop;
    logic [ADDR_BITS-1:0] wr_ptr_nxt;
    logic [ADDR_BITS-1:0] rd_ptr_nxt;
    logic [CW-1:0]        count_nxt;
    logic [7:0]           drop_cnt_nxt;
    logic                 overflow_nxt;
    logic [31:0]          head;

    // Input register; also the timing-ignore boundary from the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            golden_q <= 32'h0;
            nonce2_q <= 32'h0;
            hash2_q  <= 32'h0;
            last_q   <= 32'h0;
        end else begin
            golden_q <= golden_nonce;
            nonce2_q <= nonce2;
            hash2_q  <= hash2;
            last_q   <= golden_q;
        end
    end

    // Push/pop arbitration; a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        push         = 1'b0;
        full         = 1'b0;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        drop         = 1'b0;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        overflow_nxt = overflow;
        drop_cnt_nxt = drop_cnt;

        push    = (golden_q != last_q);
        full    = (count == CNT_FULL);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;

        if (do_push) begin
            wr_ptr_nxt = wr_ptr + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_nxt = count - CNT_ONE;
        end
        if (drop) begin
            overflow_nxt = 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt_nxt = drop_cnt + 8'd1;
            end
        end
    end

    // FIFO control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            drop_cnt <= 8'h0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            overflow <= overflow_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

    // Distributed RAM storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= golden_q;
        end
    end

    // Asynchronous head read, masked while empty.
    always_comb begin
        head = 32'h0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
    end

    assign result = {hash2_q, nonce2_q, head};

endmodule
